// File: rtl/fir_peak_detector.sv
// Frame-based peak detector for the matched-filter output stream: tracks the largest |sample|
// and its first index over FRAME_LENGTH valid samples, then emits a one-cycle report.
module fir_peak_detector #(
    parameter int unsigned DATA_WIDTH   = 24,
    parameter int unsigned FRAME_LENGTH = 256,
    parameter int unsigned INDEX_WIDTH  = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start_flag,
    input  logic                          i_abort_flag,
    input  logic                          i_data_valid,
    input  logic signed [DATA_WIDTH-1:0]  i_data_in,
    input  logic        [DATA_WIDTH-1:0]  i_threshold,
    output logic        [DATA_WIDTH-1:0]  o_peak_value,
    output logic        [INDEX_WIDTH-1:0] o_peak_index,
    output logic                          o_peak_detected,
    output logic                          o_peak_valid,
    output logic                          o_busy
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StReport = 2'd2
    } state_e;

    localparam logic [INDEX_WIDTH-1:0] LastIdx = INDEX_WIDTH'(FRAME_LENGTH - 1);

    state_e                  r_state, w_state_d;
    logic [DATA_WIDTH-1:0]   r_run_max, w_run_max_d;
    logic [INDEX_WIDTH-1:0]  r_run_idx, w_run_idx_d;
    logic [INDEX_WIDTH-1:0]  r_sample_count, w_sample_count_d;
    logic [DATA_WIDTH-1:0]   r_thr_latch, w_thr_latch_d;
    logic [DATA_WIDTH-1:0]   r_peak_value, w_peak_value_d;
    logic [INDEX_WIDTH-1:0]  r_peak_index, w_peak_index_d;
    logic                    r_peak_detected, w_peak_detected_d;
    logic                    r_peak_valid, w_peak_valid_d;
    logic                    r_busy, w_busy_d;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH-1:0]   w_mag;
    logic                    w_new_max;
    logic [DATA_WIDTH-1:0]   w_final_max;
    logic [INDEX_WIDTH-1:0]  w_final_idx;

    // Two's-complement negate in unsigned width: the most negative input lands on 2^(W-1).
    assign w_data      = i_data_in;
    assign w_mag       = w_data[DATA_WIDTH-1] ? (~w_data + DATA_WIDTH'(1)) : w_data;
    assign w_new_max   = (w_mag > r_run_max);
    assign w_final_max = w_new_max ? w_mag : r_run_max;
    assign w_final_idx = w_new_max ? r_sample_count : r_run_idx;

    always_comb begin
        w_state_d         = r_state;
        w_run_max_d       = r_run_max;
        w_run_idx_d       = r_run_idx;
        w_sample_count_d  = r_sample_count;
        w_thr_latch_d     = r_thr_latch;
        w_peak_value_d    = r_peak_value;
        w_peak_index_d    = r_peak_index;
        w_peak_detected_d = r_peak_detected;
        w_peak_valid_d    = 1'b0;

        case (r_state)
            StIdle: begin
                if (i_start_flag) begin
                    w_run_max_d      = '0;
                    w_run_idx_d      = '0;
                    w_sample_count_d = '0;
                    w_thr_latch_d    = i_threshold;
                    w_state_d        = StSearch;
                end
            end
            StSearch: begin
                if (i_abort_flag) begin
                    w_state_d = StIdle;
                end else if (i_data_valid) begin
                    w_run_max_d      = w_final_max;
                    w_run_idx_d      = w_final_idx;
                    w_sample_count_d = r_sample_count + INDEX_WIDTH'(1);
                    if (r_sample_count == LastIdx) begin
                        w_peak_value_d    = w_final_max;
                        w_peak_index_d    = w_final_idx;
                        w_peak_detected_d = (w_final_max >= r_thr_latch);
                        w_peak_valid_d    = 1'b1;
                        w_state_d         = StReport;
                    end
                end
            end
            StReport: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d        = StIdle;
                w_run_max_d      = '0;
                w_run_idx_d      = '0;
                w_sample_count_d = '0;
                w_thr_latch_d    = '0;
            end
        endcase

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= StIdle;
            r_run_max       <= '0;
            r_run_idx       <= '0;
            r_sample_count  <= '0;
            r_thr_latch     <= '0;
            r_peak_value    <= '0;
            r_peak_index    <= '0;
            r_peak_detected <= 1'b0;
            r_peak_valid    <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_run_max       <= w_run_max_d;
            r_run_idx       <= w_run_idx_d;
            r_sample_count  <= w_sample_count_d;
            r_thr_latch     <= w_thr_latch_d;
            r_peak_value    <= w_peak_value_d;
            r_peak_index    <= w_peak_index_d;
            r_peak_detected <= w_peak_detected_d;
            r_peak_valid    <= w_peak_valid_d;
            r_busy          <= w_busy_d;
        end
    end

    assign o_peak_value    = r_peak_value;
    assign o_peak_index    = r_peak_index;
    assign o_peak_detected = r_peak_detected;
    assign o_peak_valid    = r_peak_valid;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_fir_peak_detector.sv
// Directed bench for fir_peak_detector: table-driven frames on an 8-sample instance plus
// hand-written abort, reset, held-start and single-sample-frame sequences.
module tb_fir_peak_detector;

    typedef struct {
        logic               start;
        logic               abort;
        logic               valid;
        logic signed [23:0] data;
        logic        [23:0] thr;
        logic               e_vld;
        logic        [23:0] e_pv;
        logic        [7:0]  e_pi;
        logic               e_pd;
        logic               e_busy;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start, abort, valid;
    logic signed [23:0] data;
    logic        [23:0] thr;
    logic        [23:0] pv;
    logic        [7:0]  pi;
    logic               pd, pvld, busy;

    logic               start1, abort1, valid1;
    logic signed [23:0] data1;
    logic        [23:0] thr1;
    logic        [23:0] pv1;
    logic        [0:0]  pi1;
    logic               pd1, pvld1, busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_peak_detector #(.DATA_WIDTH(24), .FRAME_LENGTH(8), .INDEX_WIDTH(8)) dut (
        .i_clock(clk), .i_reset(rst), .i_start_flag(start), .i_abort_flag(abort),
        .i_data_valid(valid), .i_data_in(data), .i_threshold(thr),
        .o_peak_value(pv), .o_peak_index(pi), .o_peak_detected(pd),
        .o_peak_valid(pvld), .o_busy(busy)
    );

    fir_peak_detector #(.DATA_WIDTH(24), .FRAME_LENGTH(1), .INDEX_WIDTH(1)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_start_flag(start1), .i_abort_flag(abort1),
        .i_data_valid(valid1), .i_data_in(data1), .i_threshold(thr1),
        .o_peak_value(pv1), .o_peak_index(pi1), .o_peak_detected(pd1),
        .o_peak_valid(pvld1), .o_busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic a, input logic v,
                         input logic signed [23:0] d, input logic [23:0] t);
        start = s; abort = a; valid = v; data = d; thr = t;
    endtask

    task automatic expect8(input string tag, input logic e_vld, input logic [23:0] e_pv,
                           input logic [7:0] e_pi, input logic e_pd, input logic e_busy);
        chk({tag, ".valid"}, 32'(pvld), 32'(e_vld));
        chk({tag, ".value"}, 32'(pv), 32'(e_pv));
        chk({tag, ".index"}, 32'(pi), 32'(e_pi));
        chk({tag, ".detected"}, 32'(pd), 32'(e_pd));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    function automatic vec_t mk(input logic s, input logic a, input logic v,
                                input logic signed [23:0] d, input logic [23:0] t,
                                input logic e_vld, input logic [23:0] e_pv,
                                input logic [7:0] e_pi, input logic e_pd, input logic e_busy);
        vec_t r;
        r.start = s; r.abort = a; r.valid = v; r.data = d; r.thr = t;
        r.e_vld = e_vld; r.e_pv = e_pv; r.e_pi = e_pi; r.e_pd = e_pd; r.e_busy = e_busy;
        return r;
    endfunction

    vec_t tbl[$];
    int   samp[8];

    initial begin
        int pulses;

        // Frame A: threshold 50, peak 60 first seen at index 3.
        samp = '{3, -7, 20, -60, 15, 60, 0, 1};
        tbl.push_back(mk(1, 0, 0, 0, 50, 0, 0, 0, 0, 1));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 1, 24'(samp[i]), 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 24'(samp[7]), 0, 1, 60, 3, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 60, 3, 1, 0));
        // Frame B: threshold 100, all samples 10 with dataValid gapped.
        tbl.push_back(mk(1, 0, 0, 0, 100, 0, 60, 3, 1, 1));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 60, 3, 1, 1));
            if (i < 7) tbl.push_back(mk(0, 0, 1, 10, 0, 0, 60, 3, 1, 1));
            else       tbl.push_back(mk(0, 0, 1, 10, 0, 1, 10, 0, 0, 1));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10, 0, 0, 0));

        drive(0, 0, 0, 0, 0);
        start1 = 0; abort1 = 0; valid1 = 0; data1 = 0; thr1 = 0;
        rst = 1;
        tick();
        tick();
        expect8("reset", 0, 0, 0, 0, 0);
        chk("reset.dut1_busy", 32'(busy1), 0);
        rst = 0;
        drive(0, 0, 0, 0, 0);
        tick();
        expect8("idle", 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].start, tbl[i].abort, tbl[i].valid, tbl[i].data, tbl[i].thr);
            tick();
            expect8($sformatf("row%0d", i), tbl[i].e_vld, tbl[i].e_pv, tbl[i].e_pi,
                    tbl[i].e_pd, tbl[i].e_busy);
        end

        // Abort after 4 samples, with a simultaneous valid sample that must be ignored.
        drive(1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin drive(0, 0, 1, 100, 0); tick(); end
        drive(0, 1, 1, 1000, 0); tick();
        expect8("abort", 0, 10, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0); tick();
            expect8("post_abort", 0, 10, 0, 0, 0);
        end
        samp = '{1, 2, -3, 0, 4, -2, -5, 5};
        drive(1, 0, 0, 0, 3); tick();
        for (int i = 0; i < 8; i++) begin drive(0, 0, 1, 24'(samp[i]), 0); tick(); end
        expect8("after_abort_frame", 1, 5, 6, 1, 1);
        drive(0, 0, 0, 0, 0); tick();
        expect8("after_abort_idle", 0, 5, 6, 1, 0);

        // Reset mid-search after 5 samples, then a clean frame.
        drive(1, 0, 0, 0, 9); tick();
        for (int i = 0; i < 5; i++) begin drive(0, 0, 1, 50, 0); tick(); end
        drive(0, 0, 0, 0, 0);
        rst = 1; tick();
        rst = 0;
        expect8("midreset", 0, 0, 0, 0, 0);
        samp = '{7, -9, 2, 2, 2, 2, 2, 9};
        drive(1, 0, 0, 0, 9); tick();
        for (int i = 0; i < 8; i++) begin drive(0, 0, 1, 24'(samp[i]), 0); tick(); end
        expect8("post_reset_frame", 1, 9, 1, 1, 1);
        drive(0, 0, 0, 0, 0); tick();

        // startFlag and dataValid held high; start-cycle samples carry 1000 and must not count.
        pulses = 0;
        for (int k = 0; k < 24; k++) begin
            drive(1, 0, 1, ((k == 0) || (k == 10)) ? 24'sd1000 : 24'(k), 0);
            tick();
            if (pvld) begin
                pulses++;
                if (pulses == 1) begin
                    chk("held.first_cycle", 32'(k), 8);
                    chk("held.first_value", 32'(pv), 8);
                    chk("held.first_index", 32'(pi), 7);
                end else begin
                    chk("held.second_cycle", 32'(k), 18);
                    chk("held.second_value", 32'(pv), 18);
                    chk("held.second_index", 32'(pi), 7);
                end
            end
        end
        chk("held.pulses", 32'(pulses), 2);
        drive(0, 1, 0, 0, 0); tick();
        chk("held.abort_busy", 32'(busy), 0);
        drive(0, 0, 0, 0, 0);

        // Single-sample frames: most negative input and a below-threshold case.
        start1 = 1; thr1 = 24'h800000; tick();
        chk("fl1.busy", 32'(busy1), 1);
        start1 = 0; valid1 = 1; data1 = -24'sd8388608; tick();
        chk("fl1.valid", 32'(pvld1), 1);
        chk("fl1.value", 32'(pv1), 8388608);
        chk("fl1.index", 32'(pi1), 0);
        chk("fl1.detected", 32'(pd1), 1);
        valid1 = 0; tick();
        chk("fl1.valid_drop", 32'(pvld1), 0);
        chk("fl1.idle_busy", 32'(busy1), 0);
        start1 = 1; thr1 = 6; tick();
        start1 = 0; valid1 = 1; data1 = 5; tick();
        chk("fl1b.valid", 32'(pvld1), 1);
        chk("fl1b.value", 32'(pv1), 5);
        chk("fl1b.detected", 32'(pd1), 0);
        valid1 = 0; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_peak_detector.md
# fir_peak_detector

Frame-based peak detector that sits directly downstream of the n-tap FIR matched filter and consumes its signed `dataOut` stream. Over a frame of `FRAME_LENGTH` valid samples it tracks the largest absolute value and the sample index where it first occurs. At frame end it emits a one-cycle report with peak magnitude, index and a threshold-crossing decision. This is the target-detection stage of the pulse-compression chain.

## Interface
- `DATA_WIDTH`, default 24: width of the FIR output sample (3 × FIR input width).
- `FRAME_LENGTH`, default 256: valid samples per search frame; must be ≥ 1.
- `INDEX_WIDTH`, default 8: width of sample index/counter; 2^INDEX_WIDTH ≥ FRAME_LENGTH.

Ports:
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `startFlag`  in  1  begin a new frame (acted on only in IDLE).
- `abortFlag`  in  1  abandon the current frame without a report.
- `dataValid`  in  1  `dataIn` carries a valid FIR sample this cycle.
- `dataIn`  in  DATA_WIDTH signed  FIR output sample.
- `threshold`  in  DATA_WIDTH unsigned  detection threshold, latched at frame start.
- `peakValue`  out  DATA_WIDTH unsigned  largest |sample| of the last completed frame.
- `peakIndex`  out  INDEX_WIDTH  0-based index of that sample within its frame.
- `peakDetected`  out  1  `peakValue` ≥ latched threshold.
- `peakValid`  out  1  one-cycle pulse: report outputs just updated.
- `busy`  out  1  high in SEARCH and REPORT.

## Operation
- Magnitude: |dataIn|, computed in DATA_WIDTH unsigned. The most negative input, −2^(DATA_WIDTH−1), maps to 2^(DATA_WIDTH−1) exactly, with no saturation and no overflow.
- Internal registers:
  - `runMax` (DATA_WIDTH unsigned)
  - `runIdx`, `sampleCount` (INDEX_WIDTH)
  - `thrLatch` (DATA_WIDTH)
  - `state` (2 bits)
- FSM states: IDLE=0, SEARCH=1, REPORT=2. Unused code 3 → IDLE with internal registers cleared.
- IDLE:
  - On `startFlag`: clear `runMax`, `runIdx` and `sampleCount` to 0; latch `threshold` into `thrLatch`; go to SEARCH.
  - A `dataValid` in the same cycle as `startFlag` is not counted.
- SEARCH, on each `dataValid`:
  - If magnitude > `runMax` (strict, so the earliest sample wins ties), update `runMax` ← magnitude and `runIdx` ← `sampleCount`.
  - Increment `sampleCount`.
  - Cycles with `dataValid`=0 change nothing.
- Frame end (the accepted sample with `sampleCount` = FRAME_LENGTH−1), on that same edge:
  - `peakValue` and `peakIndex` load the final max/index, including this sample.
  - `peakDetected` ← (final max ≥ `thrLatch`).
  - `peakValid` ← 1; go to REPORT.
- REPORT: `peakValid` ← 0, go to IDLE. `startFlag` and `dataValid` are ignored here.
- `abortFlag` in SEARCH (takes priority over `dataValid`): go to IDLE. Report outputs keep their previous values and `peakValid` stays 0. `abortFlag` in IDLE or REPORT has no effect.
- `startFlag` in SEARCH or REPORT is ignored.
- Report outputs hold their values until the next frame end or `reset`.

## Timing
- Reset (synchronous, dominates all inputs): `peakValue`=0, `peakIndex`=0, `peakDetected`=0, `peakValid`=0, `busy`=0, state=IDLE. All internal registers are 0.
- `busy` is registered: high from the cycle after the `startFlag` edge through the REPORT cycle.
- Latency:
  - Report outputs and `peakValid` are visible in the cycle immediately after the edge that samples the last frame sample.
  - `peakValid` is high for exactly 1 cycle.
- Back-to-back frames: earliest next `startFlag` acceptance is the cycle after REPORT (IDLE). Minimum frame period is FRAME_LENGTH + 2 cycles.
- FRAME_LENGTH=1: the first accepted sample is both start and end of the frame, and is reported with index 0.
- Reset asserted mid-SEARCH or during REPORT: no report is produced, and `peakValid` is 0 the next cycle.

## Test plan
- FRAME_LENGTH=8, threshold=50, samples 3,−7,20,−60,15,60,0,1 → `peakValue`=60, `peakIndex`=3 (tie goes to earliest), `peakDetected`=1, and `peakValid` pulses once, the cycle after sample 8.
- FRAME_LENGTH=8, threshold=100, samples all 10 with `dataValid` gapped every other cycle → `peakValue`=10, `peakIndex`=0, `peakDetected`=0. Report arrives one cycle after the 8th valid sample.
- DATA_WIDTH=24, single sample −8388608 (FRAME_LENGTH=1) → `peakValue`=8388608, `peakIndex`=0.
- `abortFlag` after 4 samples of a frame, then a new full frame with peak 5 at index 6 → no report after the abort; the second report is `peakValue`=5, `peakIndex`=6.
- `reset` asserted during SEARCH after 5 samples → next cycle all outputs are 0 and `busy`=0. A subsequent full frame reports correctly.
- `startFlag` held high continuously with 2 back-to-back frames of 8 samples → exactly two `peakValid` pulses. The second frame starts in the IDLE cycle after REPORT, and the `dataValid` coincident with that start is not counted.
